image_stream_decryptor: RTL and testbench
=========================================

// Module: image_stream_decryptor
// PURPOSE
//  Streams encrypted image bytes from the source ROM, XORs each byte with an
//  8-bit LFSR keystream seeded from the switch key, and writes the plaintext
//  into the dual-port decryption RAM. The VGA sprite path then displays that
//  RAM. Sits between the image ROM (upstream) and the decryption RAM / VGA
//  path (downstream).
// PARAMETERS
//  IMG_BYTES  19200  bytes per image (160x120, 8-bit RGB332); max 32768
//  ADDR_W     15     ROM/RAM address width
//  ROM_LAT    1      ROM read latency in clk cycles (1..3)
// PORTS
//  clk       in   1       system clock
//  rst       in   1       asynchronous reset, active-high
//  start     in   1       1-cycle pulse: begin a full decryption pass
//  key       in   8       decryption key (switches Sw7..Sw0)
//  enable    in   1       memory-port grant; 0 = freeze (no ROM/RAM activity)
//  rom_addr  out  ADDR_W  ROM read address
//  rom_data  in   8       ROM read data, valid ROM_LAT cycles after rom_addr
//  ram_addr  out  ADDR_W  RAM write address
//  ram_din   out  8       RAM write data (plaintext)
//  ram_we    out  1       RAM write strobe, one cycle per byte
//  busy      out  1       1 while a pass is in progress
//  done      out  1       1 after the last byte is written; held until restart
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; addr counter=0; lfsr=8'h01; key_q=0.
//  - FSM states: IDLE, LOAD, FETCH, WAIT, WRITE, DONE.
//    IDLE  -> LOAD on start.
//    LOAD  : addr<=0; lfsr<=(key==0)?8'h01:key; key_q<=key; busy<=1 -> FETCH.
//    FETCH : rom_addr<=addr -> WAIT.
//    WAIT  : count ROM_LAT cycles (counter reloads on entry) -> WRITE.
//    WRITE : ram_we=1, ram_addr=addr, ram_din=rom_data^lfsr; lfsr steps once;
//            addr==IMG_BYTES-1 -> DONE, else addr<=addr+1 -> FETCH.
//    DONE  : busy=0, done=1; start -> LOAD.
//  - Throughput: 2+ROM_LAT cycles/byte (3 by default); ram_we is combinational
//    from the state (asserted only in WRITE with enable=1).
//  - LFSR: Galois, taps x^8+x^6+x^5+x^4+1 (mask 8'hB8), shift right; advances
//    exactly once per written byte, never while stalled; never reaches 0.
//  - enable=0: FSM, addr, lfsr and WAIT counter hold; ram_we forced 0;
//    rom_addr held stable, so rom_data stays valid through the stall.
//  - Key change: key!=key_q in any state except IDLE -> LOAD next cycle
//    (abort, restart from addr 0, done cleared). Takes priority over start.
//  - start while busy: ignored (a key change is the only restart).
//  - start together with the final WRITE: final write completes, then DONE.
//  - addr never exceeds IMG_BYTES-1; no wrap-around inside a pass.
//  - rst mid-pass: immediate return to reset values; the RAM keeps partial
//    contents; a new start is required.
// STRUCTURE
//  - Shared package img_pkg: state enum, LFSR_MASK=8'hB8, LFSR_SEED0=8'h01,
//    IMG_W=160, IMG_H=120, IMG_BYTES.
//  - One sub-module: stream_lfsr (8-bit Galois LFSR with load/step/seed ports).
//  - The top contains the FSM, the address counter, the WAIT counter and the
//    key-change detector.
// TESTING
//  1. ROM[i]=i[7:0], key=8'h00, start -> byte 0 = 8'h00^8'h01 = 8'h01,
//     byte 1 = 8'h01^8'hB8 = 8'hB9; done after 3*19200 cycles (+2 for start/LOAD).
//  2. key=8'hFF, full pass, then a second pass on the same ROM -> RAM equals
//     the plaintext; done=1, busy=0; exactly 19200 ram_we pulses.
//  3. enable=0 for 10 cycles during WAIT -> no ram_we, rom_addr stable,
//     written data identical to an unstalled run.
//  4. key changes 8'hFF->8'h0F at byte 500 -> next ram_addr=0 with lfsr seed
//     8'h0F; done stays 0 until the new pass completes.
//  5. rst pulse at byte 1000 -> all outputs 0 within the same cycle; start
//     ignored while busy; new start restarts at addr 0.
//  6. IMG_BYTES=4, ROM_LAT=3 -> 5 cycles/byte; done after 4 writes;
//     ram_addr = 0,1,2,3 only.

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and constants for the image stream decryptor: FSM state
// encoding, keystream LFSR constants and the image geometry.
package img_pkg;

  localparam int IMG_W     = 160;
  localparam int IMG_H     = 120;
  localparam int IMG_BYTES = IMG_W * IMG_H;

  localparam logic [7:0] LFSR_MASK  = 8'hB8;
  localparam logic [7:0] LFSR_SEED0 = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_e;

  // One Galois step, shift right: x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_MASK : 8'h00);
  endfunction

endpackage

// File: rtl/stream_lfsr.sv
// 8-bit Galois keystream generator. A zero seed is replaced by LFSR_SEED0 so
// the register can never lock up in the all-zero state.
module stream_lfsr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [7:0] seed_i,
  output logic [7:0] lfsr_o
);
  import img_pkg::*;

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // NOTE: default assignment first, so every path through the block drives lfsr_d and no latch is inferred.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == 8'h00) ? LFSR_SEED0 : seed_i;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // NOTE: non-blocking assignment for state, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/image_stream_decryptor.sv
// Streams ciphertext bytes from the image ROM, XORs them with a key-seeded
// LFSR keystream and writes the plaintext into the decryption RAM.
module image_stream_decryptor #(
  parameter int IMG_BYTES = img_pkg::IMG_BYTES,
  parameter int ADDR_W    = 15,
  parameter int ROM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        key,
  input  logic              enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  output logic              busy,
  output logic              done
);
  import img_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(IMG_BYTES - 1);
  localparam logic [1:0]        WAIT_RELOAD = 2'(ROM_LAT - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [1:0]        wait_q;
  logic [7:0]        key_q;
  logic              busy_q;
  logic              done_q;
  logic [7:0]        lfsr;
  logic              key_chg;
  logic              in_write;

  // LOAD itself captures the key, so it is excluded from the change detector.
  assign key_chg  = (state_q != ST_IDLE) && (state_q != ST_LOAD) && (key != key_q);
  assign in_write = (state_q == ST_WRITE);

  stream_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (enable && (state_q == ST_LOAD)),
    .step_i (enable && in_write),
    .seed_i (key),
    .lfsr_o (lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rom_addr_q <= '0;
      wait_q     <= '0;
      key_q      <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (enable) begin
      if (key_chg) begin
        state_q <= ST_LOAD;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state_q <= ST_LOAD;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
          ST_LOAD: begin
            addr_q  <= '0;
            key_q   <= key;
            state_q <= ST_FETCH;
          end
          ST_FETCH: begin
            rom_addr_q <= addr_q;
            wait_q     <= WAIT_RELOAD;
            state_q    <= ST_WAIT;
          end
          ST_WAIT: begin
            if (wait_q == 2'd0) begin
              state_q <= ST_WRITE;
            end else begin
              wait_q <= wait_q - 2'd1;
            end
          end
          ST_WRITE: begin
            if (addr_q == LAST_ADDR) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_FETCH;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // The write strobe is decoded from the state so the byte lands in the WRITE
  // cycle itself; the data/address buses stay at zero outside WRITE.
  assign ram_we   = enable && in_write;
  assign ram_addr = in_write ? addr_q : '0;
  assign ram_din  = in_write ? (rom_data ^ lfsr) : 8'h00;
  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_image_stream_decryptor.sv
// Directed bench: a reduced-size main instance (ROM_LAT=1) and a 4-byte
// instance (ROM_LAT=3), each with a behavioural ROM and a write monitor.
module tb_image_stream_decryptor;

  localparam int N_MAIN   = 1200;
  localparam int N_SMALL  = 4;
  localparam int CYC_PASS = 3 * N_MAIN + 2;
  localparam int LOG_N    = 16384;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  key;
  logic        enable;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic [14:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic        busy;
  logic        done;

  logic        start2;
  logic [7:0]  key2;
  logic [14:0] rom_addr2;
  logic [7:0]  rom_data2;
  logic [14:0] ram_addr2;
  logic [7:0]  ram_din2;
  logic        ram_we2;
  logic        busy2;
  logic        done2;

  int n_checks;
  int n_errors;

  image_stream_decryptor #(.IMG_BYTES(N_MAIN), .ADDR_W(15), .ROM_LAT(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .enable   (enable),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .busy     (busy),
    .done     (done)
  );

  image_stream_decryptor #(.IMG_BYTES(N_SMALL), .ADDR_W(15), .ROM_LAT(3)) dut_small (
    .clk      (clk),
    .rst      (rst),
    .start    (start2),
    .key      (key2),
    .enable   (enable),
    .rom_addr (rom_addr2),
    .rom_data (rom_data2),
    .ram_addr (ram_addr2),
    .ram_din  (ram_din2),
    .ram_we   (ram_we2),
    .busy     (busy2),
    .done     (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: main ROM[i] = i[7:0] with 1-cycle latency; small ROM is a
  // fixed 4-byte table behind a 3-stage pipeline.
  logic [7:0] rom_mem  [0:N_MAIN-1];
  logic [7:0] rom2_mem [0:N_SMALL-1];
  logic [7:0] p1, p2;

  initial begin
    for (int i = 0; i < N_MAIN; i++) rom_mem[i] = 8'(i);
    rom2_mem[0] = 8'hA5;
    rom2_mem[1] = 8'h3C;
    rom2_mem[2] = 8'h00;
    rom2_mem[3] = 8'hFF;
  end

  always @(posedge clk) begin
    rom_data  <= rom_mem[rom_addr];
    p1        <= rom2_mem[rom_addr2[1:0]];
    p2        <= p1;
    rom_data2 <= p2;
  end

  // RAM / write monitors.
  int         cyc;
  int         we_total;
  int         we2_total;
  int         max_addr;
  int         pass_id;
  logic [7:0] ram_mem [0:N_MAIN-1];
  int         wr_pass [0:N_MAIN-1];
  int         wa_log  [0:LOG_N-1];
  logic [7:0] wd_log  [0:LOG_N-1];
  int         wa2_log [0:15];
  logic [7:0] wd2_log [0:15];

  initial begin
    cyc = 0; we_total = 0; we2_total = 0; max_addr = 0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we === 1'b1) begin
      if (int'(ram_addr) < N_MAIN) begin
        ram_mem[ram_addr] <= ram_din;
        wr_pass[ram_addr] <= pass_id;
      end
      if (we_total < LOG_N) begin
        wa_log[we_total] <= int'(ram_addr);
        wd_log[we_total] <= ram_din;
      end
      if (int'(ram_addr) > max_addr) max_addr <= int'(ram_addr);
      we_total <= we_total + 1;
    end
    if (ram_we2 === 1'b1) begin
      if (we2_total < 16) begin
        wa2_log[we2_total] <= int'(ram_addr2);
        wd2_log[we2_total] <= ram_din2;
      end
      we2_total <= we2_total + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_step(input logic [7:0] s);
    logic [7:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 8'hB8;
    return n;
  endfunction

  // Whole-image comparison against ROM ^ keystream for the given key.
  task automatic check_image(input logic [7:0] k, input int pid, input string tag);
    logic [7:0] s;
    int mism;
    s = (k == 8'h00) ? 8'h01 : k;
    mism = 0;
    for (int i = 0; i < N_MAIN; i++) begin
      if (ram_mem[i] !== (rom_mem[i] ^ s) || wr_pass[i] != pid) mism++;
      s = model_step(s);
    end
    check(tag, 64'(mism), 64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_writes(input int base, input int n, input string tag);
    int guard;
    guard = 0;
    while (we_total - base < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 64'(we_total - base >= n), 64'd1);
  endtask

  task automatic wait_done(input int c0, input string tag, input int exp_cycles);
    do @(negedge clk); while (done !== 1'b1 && cyc - c0 < 20000);
    check(tag, 64'(cyc - c0), 64'(exp_cycles));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int base, c0, c1, b4, wc, bad;
    logic [14:0] ra;
    n_checks = 0; n_errors = 0; pass_id = 0;
    rst = 1'b1; start = 1'b0; key = 8'h00; enable = 1'b1;
    start2 = 1'b0; key2 = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_main_outputs", 64'({rom_addr, ram_addr, ram_din, ram_we, busy, done}), 64'd0);
    check("rst_small_outputs", 64'({rom_addr2, ram_addr2, ram_din2, ram_we2, busy2, done2}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_busy", 64'({busy, done}), 64'd0);

    // Pass with key 00: seed falls back to 01.
    pass_id = 1; base = we_total; c0 = cyc;
    pulse_start();
    wait_done(c0, "t1_cycles", CYC_PASS);
    check("t1_writes", 64'(we_total - base), 64'(N_MAIN));
    check("t1_b0_addr", 64'(wa_log[base]), 64'd0);
    check("t1_b0_data", 64'(wd_log[base]), 64'h01);
    check("t1_b1_addr", 64'(wa_log[base + 1]), 64'd1);
    check("t1_b1_data", 64'(wd_log[base + 1]), 64'hB9);
    check("t1_b2_data", 64'(wd_log[base + 2]), 64'h5E);
    check("t1_busy_at_done", 64'(busy), 64'd0);
    check_image(8'h00, 1, "t1_image");
    repeat (5) @(negedge clk);
    check("t1_done_held", 64'({busy, done}), 64'b01);

    // Key change in DONE restarts with key FF; a mid-pass start is ignored.
    pass_id = 2; base = we_total;
    key = 8'hFF; c0 = cyc;
    @(negedge clk);
    check("t2_restart_flags", 64'({busy, done}), 64'b10);
    wait_writes(base, 300, "t2_reach300");
    pulse_start();
    wait_done(c0, "t2_cycles", CYC_PASS);
    check("t2_writes", 64'(we_total - base), 64'(N_MAIN));
    check("t2_b0_data", 64'(wd_log[base]), 64'hFF);
    check("t2_b1_data", 64'(wd_log[base + 1]), 64'hC6);
    check("t2_b2_data", 64'(wd_log[base + 2]), 64'hD9);
    check_image(8'hFF, 2, "t2_image");

    // Same key again, with a 10-cycle stall in WAIT and a 2-cycle stall in WRITE.
    pass_id = 3; base = we_total; c0 = cyc;
    pulse_start();
    wait_writes(base, 100, "t3_reach100");
    @(negedge clk);
    enable = 1'b0;
    ra = rom_addr; wc = we_total; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (ram_we !== 1'b0 || rom_addr !== ra) bad++;
    end
    check("t3_stall_quiet", 64'(bad), 64'd0);
    check("t3_stall_no_write", 64'(we_total - wc), 64'd0);
    enable = 1'b1;
    wait_writes(base, 200, "t3_reach200");
    @(negedge clk);
    @(negedge clk);
    check("t3_we_in_write", 64'(ram_we), 64'd1);
    enable = 1'b0;
    #1;
    check("t3_we_gated", 64'(ram_we), 64'd0);
    wc = we_total;
    repeat (2) @(negedge clk);
    check("t3_write_frozen", 64'(we_total - wc), 64'd0);
    enable = 1'b1;
    wait_done(c0, "t3_cycles", CYC_PASS + 12);
    check("t3_writes", 64'(we_total - base), 64'(N_MAIN));
    check_image(8'hFF, 3, "t3_image");

    // Key FF -> 0F after 500 bytes: abort and restart from address 0.
    pass_id = 4; base = we_total; c0 = cyc;
    pulse_start();
    wait_writes(base, 500, "t4_reach500");
    key = 8'h0F; c1 = cyc; b4 = we_total;
    @(negedge clk);
    check("t4_abort_flags", 64'({busy, done}), 64'b10);
    wait_done(c1, "t4_cycles", CYC_PASS);
    check("t4_pre_abort_writes", 64'(b4 - base), 64'd500);
    check("t4_writes_after_abort", 64'(we_total - b4), 64'(N_MAIN));
    check("t4_b0_addr", 64'(wa_log[b4]), 64'd0);
    check("t4_b0_data", 64'(wd_log[b4]), 64'h0F);
    check("t4_b1_data", 64'(wd_log[b4 + 1]), 64'hBE);
    check_image(8'h0F, 4, "t4_image");

    // Reset mid-pass after 1000 bytes, then a fresh start.
    pass_id = 5; base = we_total;
    pulse_start();
    wait_writes(base, 1000, "t5_reach1000");
    rst = 1'b1;
    #1;
    check("t5_rst_outputs", 64'({rom_addr, ram_addr, ram_din, ram_we, busy, done}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wc = we_total;
    repeat (5) @(negedge clk);
    check("t5_idle_after_rst", 64'({busy, done}), 64'd0);
    check("t5_no_writes_idle", 64'(we_total - wc), 64'd0);
    pass_id = 6; base = we_total; c0 = cyc;
    pulse_start();
    wait_done(c0, "t5_cycles", CYC_PASS);
    check("t5_b0_addr", 64'(wa_log[base]), 64'd0);
    check("t5_writes", 64'(we_total - base), 64'(N_MAIN));
    check_image(8'h0F, 6, "t5_image");
    check("max_ram_addr", 64'(max_addr), 64'(N_MAIN - 1));

    // 4-byte image, ROM_LAT=3: 5 cycles/byte; start during the final WRITE.
    base = we2_total; key2 = 8'h5A; c0 = cyc;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    while (!(ram_we2 === 1'b1 && we2_total - base == 3) && cyc - c0 < 200) @(negedge clk);
    check("t6_final_write_addr", 64'(ram_addr2), 64'd3);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("t6_cycles", 64'(cyc - c0), 64'd22);
    check("t6_done_flags", 64'({busy2, done2}), 64'b01);
    repeat (3) @(negedge clk);
    check("t6_done_held", 64'({busy2, done2}), 64'b01);
    check("t6_writes", 64'(we2_total - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_addr%0d", i), 64'(wa2_log[base + i]), 64'(i));
    end
    check("t6_b0_data", 64'(wd2_log[base]), 64'hFF);
    check("t6_b1_data", 64'(wd2_log[base + 1]), 64'h11);
    check("t6_b2_data", 64'(wd2_log[base + 2]), 64'hAE);
    check("t6_b3_data", 64'(wd2_log[base + 3]), 64'hA8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
